// File: rtl/key_pulse_debouncer_pkg.sv
// Shared key front-end types and timing defaults.
// Used by every key-driven block in the PWM control path.
package key_pulse_debouncer_pkg;

  typedef enum logic [2:0] {
    KEY_IDLE         = 3'd0,
    KEY_PRESS_WAIT   = 3'd1,
    KEY_HELD         = 3'd2,
    KEY_REPEAT       = 3'd3,
    KEY_RELEASE_WAIT = 3'd4
  } key_state_e;

  localparam int unsigned KEY_CLK_HZ        = 50_000_000;
  localparam int unsigned KEY_DEBOUNCE_DEF  = 1_000_000;
  localparam int unsigned KEY_REP_DELAY_DEF = 25_000_000;
  localparam int unsigned KEY_REP_PERIOD_DEF = 5_000_000;
  localparam int unsigned KEY_COUNT         = 4;

  function automatic int unsigned key_max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_pulse_debouncer_fsm.sv
// One key: two-flop synchroniser, shared timer and
// press/hold/repeat/release FSM with registered outputs.
import key_pulse_debouncer_pkg::*;

module key_debounce_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES      = KEY_DEBOUNCE_DEF,
  parameter bit          REPEAT_EN            = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = KEY_REP_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD_CYCLES = KEY_REP_PERIOD_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic key_n,
  output logic pulse,
  output logic level
);

  localparam int unsigned CMAX = key_max3(DEBOUNCE_CYCLES,
                                          REPEAT_DELAY_CYCLES,
                                          REPEAT_PERIOD_CYCLES);
  localparam int unsigned CW = (CMAX > 2) ? $clog2(CMAX) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY_CYCLES - 1);
  localparam cnt_t RP_LAST = cnt_t'(REPEAT_PERIOD_CYCLES - 1);

  logic [1:0] sync_q;
  logic       down;

  key_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       pulse_q, pulse_d;
  logic       level_q, level_d;

  // Synchroniser resets to released so a held key looks fresh.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign down = ~sync_q[1];

  // State, timer and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next state: debounce both edges, then time repeats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    unique case (state_q)
      KEY_IDLE: begin
        if (down) begin
          state_d = KEY_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      KEY_PRESS_WAIT: begin
        if (!down) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = KEY_HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_HELD: begin
        if (!down) begin
          state_d = KEY_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == RD_LAST) begin
          state_d = KEY_REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_REPEAT: begin
        if (!down) begin
          state_d = KEY_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_RELEASE_WAIT: begin
        if (down) begin
          state_d = KEY_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/key_pulse_debouncer.sv
// Four independent debounced keys with press and
// auto-repeat pulses for the PWM duty-control stage.
import key_pulse_debouncer_pkg::*;

module key_pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES      = KEY_DEBOUNCE_DEF,
  parameter bit          REPEAT_EN            = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = KEY_REP_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD_CYCLES = KEY_REP_PERIOD_DEF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] keys_n,
  output logic [3:0] key_pulse,
  output logic [3:0] key_level
);

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_EN            (REPEAT_EN),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_key (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .key_n (keys_n[g]),
      .pulse (key_pulse[g]),
      .level (key_level[g])
    );
  end

endmodule
